// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD <-> binary conversion paths (keypad entry
// and display). Holds the converter FSM state encoding, the double-dabble
// correction constants and a small digit-validity helper.
// No ports (package).
// ---------------------------------------------------------------------------
package bcd_pkg;

  // Converter FSM state encoding
  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] CONVERTE = 2'd1;
  localparam logic [1:0] AJUSTA   = 2'd2;
  localparam logic [1:0] FIM      = 2'd3;

  // Reverse double-dabble: after each right shift, a nibble at or above
  // BCD_LIMIAR holds a borrowed "8" that is really worth 5, so subtract 3.
  localparam logic [3:0] BCD_LIMIAR     = 4'd8;
  localparam logic [3:0] BCD_CORRECAO   = 4'd3;
  localparam logic [3:0] BCD_MAX_DIGITO = 4'd9;

  // True when a nibble is not a legal decimal digit
  function automatic logic digito_invalido(input logic [3:0] digito);
    return (digito > BCD_MAX_DIGITO);
  endfunction

endpackage

// File: rtl/ajuste_digito_bcd.sv
// ---------------------------------------------------------------------------
// ajuste_digito_bcd
// Combinational per-nibble correction used by the reverse double-dabble
// converter: out = (in >= 8) ? in - 3 : in. The subtraction is only applied
// to nibbles of 8 or more, so it can never underflow in 4 bits.
// Ports:
//   digito_i  in  4  nibble after the right shift
//   digito_o  out 4  corrected nibble
// ---------------------------------------------------------------------------
module ajuste_digito_bcd
  import bcd_pkg::*;
(
  input  logic [3:0] digito_i,
  output logic [3:0] digito_o
);

  assign digito_o = (digito_i >= BCD_LIMIAR) ? (digito_i - BCD_CORRECAO) : digito_i;

endmodule

// File: rtl/bcd_para_binario.sv
// ---------------------------------------------------------------------------
// bcd_para_binario
// Sequential BCD-to-binary converter: sign + NDIG packed BCD digits become a
// LARG-bit two's complement integer. One reverse double-dabble step per
// clock, start/busy/done handshake, and detection of invalid digits.
// Parameters:
//   NDIG  number of BCD digits (1..8)
//   LARG  width of the binary result (must be >= 4*NDIG+1)
// Ports:
//   clock    in   1       system clock, rising edge
//   reset    in   1       synchronous, active-low reset
//   inicio   in   1       start request, only honoured while idle
//   sinal    in   1       sign of the entered number (1 = negative)
//   digitos  in   4*NDIG  packed BCD, [3:0] = units, [7:4] = tens, ...
//   ocupado  out  1       high from accepted start until FIM exits
//   pronto   out  1       one-cycle completion pulse
//   erro     out  1       some captured digit was above 9 (held)
//   numero   out  LARG    result, held until the next completion
// ---------------------------------------------------------------------------
module bcd_para_binario
  import bcd_pkg::*;
#(
  parameter int NDIG = 2,
  parameter int LARG = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inicio,
  input  logic                sinal,
  input  logic [4*NDIG-1:0]   digitos,
  output logic                ocupado,
  output logic                pronto,
  output logic                erro,
  output logic [LARG-1:0]     numero
);

  localparam int NBITS = 4 * NDIG;
  localparam int CW    = $clog2(NBITS + 1);
  localparam logic [CW-1:0] ULTIMO_PASSO = CW'(NBITS - 1);

  // State and datapath registers
  logic [1:0]         estado_q, estado_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*NBITS-1:0] shreg_q, shreg_d;
  logic               sinal_q, sinal_d;
  logic               erro_q, erro_d;
  logic [LARG-1:0]    numero_q, numero_d;

  // Combinational helpers
  logic [2*NBITS-1:0] deslocado;
  logic [NBITS-1:0]   bcd_corrigido;
  logic [2*NBITS-1:0] passo;
  logic [NDIG-1:0]    nibble_invalido;
  logic               algum_invalido;
  logic [LARG-1:0]    magnitude;
  logic [LARG-1:0]    resultado;

  // The shift register is {bcd, bin}; one step moves the bcd LSB into the
  // bin MSB, then every bcd nibble is corrected independently.
  assign deslocado = shreg_q >> 1;

  for (genvar g = 0; g < NDIG; g++) begin : g_digito
    ajuste_digito_bcd u_ajuste (
      .digito_i (deslocado[NBITS + 4*g +: 4]),
      .digito_o (bcd_corrigido[4*g +: 4])
    );

    assign nibble_invalido[g] = digito_invalido(digitos[4*g +: 4]);
  end

  assign passo          = {bcd_corrigido, deslocado[NBITS-1:0]};
  assign algum_invalido = |nibble_invalido;

  // Sign stage: zero-extend the magnitude and negate in the full result
  // width. An invalid entry always yields zero, and -0 is naturally 0.
  assign magnitude = LARG'(shreg_q[NBITS-1:0]);
  assign resultado = erro_q ? '0 : (sinal_q ? (-magnitude) : magnitude);

  // Next-state logic for the FSM and the datapath registers
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    sinal_d  = sinal_q;
    erro_d   = erro_q;
    numero_d = numero_q;

    case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          shreg_d  = {digitos, {NBITS{1'b0}}};
          sinal_d  = sinal;
          erro_d   = algum_invalido;
          cnt_d    = '0;
          estado_d = CONVERTE;
        end
      end

      CONVERTE: begin
        shreg_d = passo;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == ULTIMO_PASSO) begin
          estado_d = AJUSTA;
        end
      end

      AJUSTA: begin
        numero_d = resultado;
        estado_d = FIM;
      end

      FIM: begin
        estado_d = OCIOSO;
      end

      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // State registers; a low reset aborts any conversion and clears the result
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      cnt_q    <= '0;
      shreg_q  <= '0;
      sinal_q  <= 1'b0;
      erro_q   <= 1'b0;
      numero_q <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      sinal_q  <= sinal_d;
      erro_q   <= erro_d;
      numero_q <= numero_d;
    end
  end

  // Moore outputs decoded from the registered state
  assign ocupado = (estado_q != OCIOSO);
  assign pronto  = (estado_q == FIM);
  assign erro    = erro_q;
  assign numero  = numero_q;

endmodule

// File: tb/tb_bcd_para_binario.sv
// ---------------------------------------------------------------------------
// tb_bcd_para_binario
// Self-checking bench for the BCD-to-binary converter (NDIG=2, LARG=32).
// Expected results come from a decimal reference model working on digit
// values with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_bcd_para_binario;

  localparam int NDIG    = 2;
  localparam int LARG    = 32;
  localparam int LATENCY = 4*NDIG + 2;

  logic            clock;
  logic            reset;
  logic            inicio;
  logic            sinal;
  logic [7:0]      digitos;
  logic            ocupado;
  logic            pronto;
  logic            erro;
  logic [LARG-1:0] numero;

  int nChecks = 0;
  int nFail   = 0;

  bcd_para_binario #(.NDIG(NDIG), .LARG(LARG)) dut (
    .clock   (clock),
    .reset   (reset),
    .inicio  (inicio),
    .sinal   (sinal),
    .digitos (digitos),
    .ocupado (ocupado),
    .pronto  (pronto),
    .erro    (erro),
    .numero  (numero)
  );

  // Free-running clock, period 10
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Decimal reference: value of the digits, sign applied, zero on bad digit
  function automatic logic [31:0] refModel(input logic s, input logic [7:0] d, output logic e);
    int mag;
    int nib;
    mag = 0;
    e   = 1'b0;
    for (int i = NDIG-1; i >= 0; i--) begin
      nib = int'(d[4*i +: 4]);
      if (nib > 9) e = 1'b1;
      mag = mag * 10 + nib;
    end
    if (e) return 32'd0;
    return s ? 32'(-mag) : 32'(mag);
  endfunction

  // Present a start request for one cycle; returns at the negedge after E0
  task automatic iniciar(input logic s, input logic [7:0] d);
    inicio  = 1'b1;
    sinal   = s;
    digitos = d;
    @(negedge clock);
    inicio  = 1'b0;
  endtask

  // Wait (bounded) for pronto; n counts edges since and including E0
  task automatic esperarPronto(output int n);
    n = 1;
    while (!pronto && n < 4*LATENCY) begin
      @(negedge clock);
      n++;
    end
    if (!pronto) checkOutput("pronto_timeout", {31'b0, pronto}, 32'd1);
  endtask

  // Full conversion from an idle negedge; ends on the idle negedge after FIM
  task automatic applyStimulus(input logic s, input logic [7:0] d, input string tag);
    logic [31:0] expNum;
    logic        expErr;
    int          n;
    expNum = refModel(s, d, expErr);
    iniciar(s, d);
    checkOutput({tag, "_ocupado_start"}, {31'b0, ocupado}, 32'd1);
    esperarPronto(n);
    checkOutput({tag, "_latency"}, n, LATENCY);
    checkOutput({tag, "_numero"}, numero, expNum);
    checkOutput({tag, "_erro"}, {31'b0, erro}, {31'b0, expErr});
    @(negedge clock);
    checkOutput({tag, "_pronto_pulse"}, {31'b0, pronto}, 32'd0);
    checkOutput({tag, "_ocupado_end"}, {31'b0, ocupado}, 32'd0);
    checkOutput({tag, "_held"}, numero, expNum);
  endtask

  initial begin
    int n;
    int seen;
    logic [7:0] d;
    logic e;

    reset   = 1'b0;
    inicio  = 1'b0;
    sinal   = 1'b0;
    digitos = 8'h00;

    // Reset held for two cycles, then released
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("reset_numero",  numero, 32'd0);
    checkOutput("reset_pronto",  {31'b0, pronto}, 32'd0);
    checkOutput("reset_ocupado", {31'b0, ocupado}, 32'd0);
    checkOutput("reset_erro",    {31'b0, erro}, 32'd0);

    // Directed cases; consecutive calls also exercise back-to-back starts
    applyStimulus(1'b0, 8'h42, "pos42");
    checkOutput("pos42_value", numero, 32'h0000002A);
    applyStimulus(1'b1, 8'h99, "neg99");
    checkOutput("neg99_value", numero, 32'hFFFFFF9D);
    applyStimulus(1'b1, 8'h00, "negzero");
    applyStimulus(1'b0, 8'h3A, "invalid");
    checkOutput("invalid_erro", {31'b0, erro}, 32'd1);
    applyStimulus(1'b0, 8'h07, "after_invalid");
    checkOutput("after_invalid_value", numero, 32'd7);

    // Start requests during conversion are ignored
    iniciar(1'b0, 8'h42);
    n = 1;
    while (!pronto && n < 4*LATENCY) begin
      inicio  = 1'b1;
      digitos = 8'($urandom);
      sinal   = 1'($urandom);
      @(negedge clock);
      n++;
    end
    inicio = 1'b0;
    checkOutput("ignore_latency", n, LATENCY);
    checkOutput("ignore_numero", numero, 32'd42);
    checkOutput("ignore_erro", {31'b0, erro}, 32'd0);
    @(negedge clock);
    checkOutput("ignore_idle", {31'b0, ocupado}, 32'd0);

    // Reset in the fourth cycle of a conversion aborts it
    applyStimulus(1'b1, 8'h55, "pre_abort");
    iniciar(1'b0, 8'h3F);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("abort_ocupado", {31'b0, ocupado}, 32'd0);
    checkOutput("abort_numero",  numero, 32'd0);
    checkOutput("abort_pronto",  {31'b0, pronto}, 32'd0);
    checkOutput("abort_erro",    {31'b0, erro}, 32'd0);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 2*LATENCY; i++) begin
      @(negedge clock);
      if (pronto || ocupado) seen++;
    end
    checkOutput("abort_no_pronto", seen, 0);

    // Exhaustive -99..+99 (both zero signs)
    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 100; v++) begin
        d = {4'(v / 10), 4'(v % 10)};
        applyStimulus(1'(s), d, "sweep");
      end
    end

    // Random patterns, including invalid nibbles
    for (int i = 0; i < 100; i++) begin
      d = 8'($urandom);
      void'(refModel(1'b0, d, e));
      applyStimulus(1'($urandom), d, e ? "rand_bad" : "rand_ok");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
